pwm_dac_mc: RTL and testbench
=============================

Name: pwm_dac_mc

Overview:
Multi-channel PWM audio DAC and the parametrised successor of the single-channel handshake-fed PWM DAC.
- The CPU side pushes one frame per four-phase req/ack handshake. A frame is one duty word per channel.
- Frames are buffered in a FIFO and applied to all channels together at a PWM period boundary, so updates are glitch-free.
- Status outputs report FIFO occupancy and underflow to the MMIO layer.

Parameters:
WIDTH, 12, duty-cycle resolution in bits; PWM period is 2^WIDTH cycles
CHANNELS, 2, number of PWM outputs
FIFO_DEPTH, 8, frame FIFO depth; power of two, >=2

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  run enable; low freezes PWM counter and pops
din  in  CHANNELS*WIDTH  frame; channel i at din[i*WIDTH +: WIDTH]
req  in  1  four-phase request; din stable while req high
ack  out  1  four-phase acknowledge
pwm  out  CHANNELS  PWM outputs, bit i = channel i
fifo_count  out  $clog2(FIFO_DEPTH)+1  frames buffered
fifo_full  out  1  fifo_count == FIFO_DEPTH
fifo_empty  out  1  fifo_count == 0
underflow  out  1  one-cycle pulse, period boundary with empty FIFO

Behaviour:
Reset (async, immediate):
- ack=0, pwm=0, FIFO empty (count 0, full 0, empty 1), underflow=0.
- PWM counter 0; all duty registers 0.

Handshake receiver, 2 states:
- IDLE: at an edge with req=1 and FIFO not full, push din and go to ACKED; ack=1 from that edge (registered, 1-cycle latency).
- IDLE with req=1 and FIFO full: stall, ack stays 0, no push. Retry every cycle until space frees.
- ACKED: ack held 1 while req=1. On the edge where req=0, go to IDLE and set ack=0.
- Exactly one push per handshake regardless of how long req stays high.

PWM counter:
- cnt is WIDTH bits, counts 0..2^WIDTH-1 and wraps, when en=1.
- en=0: cnt held, no pops, pwm forced 0 (registered). FIFO pushes still accepted.

Period boundary (edge where en=1 and cnt==2^WIDTH-1):
- FIFO not empty: pop one frame into all duty registers at once; new duties apply from cnt=0.
- FIFO empty: underflow=1 for that cycle; duty per the Optional Feature.

Output compare:
- pwm[i] registered: pwm[i] <= en && (cnt < duty[i]), using unsigned compare on current values. Output lags cnt by 1 cycle.
- duty=0: pwm constantly 0.
- duty=2^WIDTH-1: high 2^WIDTH-1 of every 2^WIDTH cycles.

FIFO:
- Circular buffer with wrap-around pointers.
- Push and pop on the same edge: both occur and count is unchanged. This is legal even when full, because the pop frees the slot first, so the stall check uses count after pop.
- Pop while empty never corrupts pointers.
- Status outputs are registered and consistent with the FIFO contents after each edge.

Reset mid-handshake:
- ack drops immediately and any captured frame is discarded.
- The sender must deassert req before starting a new frame. A req still high after reset release is treated as a new request.

Optional Feature:
Macro PWM_DAC_MC_UNDERFLOW_MUTE_EN.
- Defined: on underflow all duty registers load midscale 2^(WIDTH-1), so output is silence at 50% duty.
- Undefined: on underflow duty registers hold their last values.
- underflow pulse is generated in both builds.

Test Plan (WIDTH=4, CHANNELS=2, FIFO_DEPTH=4):
- Reset held, then released with req=0 -> ack=0, pwm=00, fifo_count=0, fifo_empty=1.
- en=1; push frame {ch1=4'd12, ch0=4'd3} -> ack rises 1 cycle after req. From the next period boundary, pwm[0] is high 3/16 cycles and pwm[1] high 12/16, per period.
- Push 4 frames without popping (en=0) -> fifo_full=1. A 5th req gets no ack. Set en=1; at the first boundary the pop occurs, the 5th frame is pushed the same edge, and fifo_count stays 4.
- Frames with ch0=0 and ch0=15 -> pwm[0] constantly 0 for the first period; then 15 high and 1 low cycle per period.
- FIFO drained with en=1 -> underflow pulses once per period. With macro defined, both duties become 8 (8/16 high). Without it, the last duties persist.
- Assert rst while ack=1 and 2 frames buffered -> ack, pwm, and fifo_count go to 0 asynchronously. Holding req high after release produces a fresh push.

Source files
------------

// File: rtl/pwm_dac_mc_if.sv
// CPU-side frame handshake for pwm_dac_mc: one duty word per channel, moved
// with a four-phase req/ack exchange.
interface pwm_dac_mc_if #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned CHANNELS = 2
);
  logic [CHANNELS*WIDTH-1:0] din;
  logic                      req;
  logic                      ack;

  modport master (output din, output req, input ack);
  modport slave  (input din, input req, output ack);
endinterface

// File: rtl/pwm_dac_mc.sv
// Multi-channel PWM DAC: frames arrive over a four-phase handshake, queue in a
// FIFO and load into all duty registers together at a PWM period boundary.
// Optional macro PWM_DAC_MC_UNDERFLOW_MUTE_EN: an underflow loads midscale duty.
module pwm_dac_mc #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  pwm_dac_mc_if.slave                 bus,
  output logic [CHANNELS-1:0]         pwm,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic                        underflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = CHANNELS * WIDTH;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {
    HS_IDLE,
    HS_ACKED
  } hs_state_e;

  hs_state_e           hs_state_q, hs_state_d;
  logic                ack_q, ack_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [FW-1:0]       duty_q, duty_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                underflow_q, underflow_d;

  logic [FW-1:0]       mem_q [FIFO_DEPTH];
  logic [FW-1:0]       mem_d [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;

  logic                boundary;
  logic                pop;
  logic                push;

  always_comb begin
    boundary = en && (cnt_q == CNT_MAX);
    pop      = boundary && (count_q != '0);
  end

  // A full FIFO still accepts a push on the edge that pops, since the pop frees a slot.
  always_comb begin
    hs_state_d = hs_state_q;
    push       = 1'b0;
    unique case (hs_state_q)
      HS_IDLE: begin
        if (bus.req && ((count_q != DEPTH_C) || pop)) begin
          push       = 1'b1;
          hs_state_d = HS_ACKED;
        end
      end
      HS_ACKED: begin
        if (!bus.req) begin
          hs_state_d = HS_IDLE;
        end
      end
      default: hs_state_d = HS_IDLE;
    endcase
    ack_d = (hs_state_d == HS_ACKED);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  // Compare uses the duty in force this cycle, so pwm trails cnt by one clock.
  always_comb begin
    cnt_d       = en ? cnt_q + 1'b1 : cnt_q;
    duty_d      = duty_q;
    underflow_d = boundary && (count_q == '0);
    if (pop) begin
      duty_d = mem_q[rd_ptr_q];
    end
`ifdef PWM_DAC_MC_UNDERFLOW_MUTE_EN
    else if (underflow_d) begin
      duty_d = {CHANNELS{1'b1, {(WIDTH-1){1'b0}}}};
    end
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = en && (cnt_q < duty_q[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_state_q  <= HS_IDLE;
      ack_q       <= 1'b0;
      cnt_q       <= '0;
      duty_q      <= '0;
      pwm_q       <= '0;
      underflow_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      hs_state_q  <= hs_state_d;
      ack_q       <= ack_d;
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      pwm_q       <= pwm_d;
      underflow_q <= underflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      mem_q       <= mem_d;
    end
  end

  assign bus.ack    = ack_q;
  assign pwm        = pwm_q;
  assign fifo_count = count_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_pwm_dac_mc.sv
// Self-checking bench for pwm_dac_mc (WIDTH=4, CHANNELS=2, FIFO_DEPTH=4):
// vector table, hand-written period/reset sequences and a random run vs a queue model.
module tb_pwm_dac_mc;

  localparam int W  = 4;
  localparam int CH = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [CH-1:0] pwm;
  logic [2:0]    fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          underflow;

  pwm_dac_mc_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  pwm_dac_mc #(.WIDTH(W), .CHANNELS(CH), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bus        (bus),
    .pwm        (pwm),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: frame queue, free-running period counter, per-channel duty.
  logic [CH*W-1:0] m_q[$];
  bit              m_busy;
  int              m_cnt;
  int              m_duty[CH];
  bit [CH-1:0]     m_pwm;
  bit              m_uf;

  function automatic void model_reset();
    m_q.delete();
    m_busy = 0;
    m_cnt  = 0;
    for (int i = 0; i < CH; i++) m_duty[i] = 0;
    m_pwm = '0;
    m_uf  = 0;
  endfunction

  function automatic void model_edge(bit e, bit r, logic [CH*W-1:0] d);
    int              occ;
    bit              bnd;
    logic [CH*W-1:0] frame;
    occ = m_q.size();
    bnd = e && (m_cnt == (1 << W) - 1);
    for (int i = 0; i < CH; i++) m_pwm[i] = e && (m_cnt < m_duty[i]);
    m_uf = bnd && (occ == 0);
    if (bnd && occ > 0) begin
      frame = m_q.pop_front();
      for (int i = 0; i < CH; i++) m_duty[i] = int'(frame[i*W +: W]);
    end else if (m_uf) begin
`ifdef PWM_DAC_MC_UNDERFLOW_MUTE_EN
      for (int i = 0; i < CH; i++) m_duty[i] = 1 << (W - 1);
`endif
    end
    if (!m_busy) begin
      if (r && m_q.size() < D) begin
        m_q.push_back(d);
        m_busy = 1;
      end
    end else if (!r) begin
      m_busy = 0;
    end
    if (e) m_cnt = (m_cnt + 1) % (1 << W);
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check_output("ack", 32'(bus.ack), 32'(m_busy));
    check_output("pwm", 32'(pwm), 32'(m_pwm));
    check_output("fifo_count", 32'(fifo_count), m_q.size());
    check_output("fifo_full", 32'(fifo_full), 32'(m_q.size() == D));
    check_output("fifo_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
    check_output("underflow", 32'(underflow), 32'(m_uf));
  endtask

  // One clock: inputs seen at the edge feed the model, outputs sampled 1ns later.
  task automatic apply_stimulus();
    bit              e;
    bit              r;
    logic [CH*W-1:0] d;
    e = en;
    r = bus.req;
    d = bus.din;
    @(posedge clk);
    #1;
    model_edge(e, r, d);
    compare_model();
  endtask

  task automatic measure_period(output int h0, output int h1, output int uf);
    h0 = 0;
    h1 = 0;
    uf = 0;
    repeat (1 << W) begin
      apply_stimulus();
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
      uf += int'(underflow);
    end
  endtask

  function automatic logic [W-1:0] pick_duty();
    int s;
    s = $urandom_range(0, 3);
    if (s == 0) return '0;
    if (s == 1) return '1;
    return W'($urandom_range(0, (1 << W) - 1));
  endfunction

  typedef struct {
    bit              req;
    logic [CH*W-1:0] din;
    bit              exp_ack;
    int              exp_count;
    bit              exp_full;
  } vec_t;

  typedef struct {
    int h0;
    int h1;
    int uf;
  } period_t;

  vec_t    tbl[10];
  period_t per[7];

  initial begin
    int k;
    int h0, h1, uf;
    int push_pct[4];

    tbl[0] = '{1, 8'hC3, 1, 1, 0};
    tbl[1] = '{0, 8'hC3, 0, 1, 0};
    tbl[2] = '{1, 8'h50, 1, 2, 0};
    tbl[3] = '{0, 8'h50, 0, 2, 0};
    tbl[4] = '{1, 8'hAF, 1, 3, 0};
    tbl[5] = '{0, 8'hAF, 0, 3, 0};
    tbl[6] = '{1, 8'h96, 1, 4, 1};
    tbl[7] = '{0, 8'h96, 0, 4, 1};
    tbl[8] = '{1, 8'h7E, 0, 4, 1};
    tbl[9] = '{1, 8'h7E, 0, 4, 1};

    per[0] = '{3, 12, 0};
    per[1] = '{0, 5, 0};
    per[2] = '{15, 10, 0};
    per[3] = '{6, 9, 0};
    per[4] = '{14, 7, 1};
`ifdef PWM_DAC_MC_UNDERFLOW_MUTE_EN
    per[5] = '{8, 8, 1};
    per[6] = '{8, 8, 1};
`else
    per[5] = '{14, 7, 1};
    per[6] = '{14, 7, 1};
`endif

    push_pct = '{50, 5, 90, 0};

    rst     = 1'b1;
    en      = 1'b0;
    bus.req = 1'b0;
    bus.din = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_ack", 32'(bus.ack), 0);
    check_output("reset_pwm", 32'(pwm), 0);
    check_output("reset_count", 32'(fifo_count), 0);
    check_output("reset_empty", 32'(fifo_empty), 1);
    check_output("reset_full", 32'(fifo_full), 0);
    check_output("reset_underflow", 32'(underflow), 0);
    rst = 1'b0;
    apply_stimulus();

    for (int i = 0; i < 10; i++) begin
      bus.req = tbl[i].req;
      bus.din = tbl[i].din;
      apply_stimulus();
      check_output($sformatf("tbl%0d_ack", i), 32'(bus.ack), 32'(tbl[i].exp_ack));
      check_output($sformatf("tbl%0d_count", i), 32'(fifo_count), 32'(tbl[i].exp_count));
      check_output($sformatf("tbl%0d_full", i), 32'(fifo_full), 32'(tbl[i].exp_full));
    end

    en = 1'b1;
    for (k = 1; k <= 40; k++) begin
      apply_stimulus();
      if (bus.ack) break;
    end
    check_output("stall_release_cycle", k, 16);
    check_output("push_pop_full_count", 32'(fifo_count), 4);
    bus.req = 1'b0;

    for (int p = 0; p < 7; p++) begin
      measure_period(h0, h1, uf);
      check_output($sformatf("period%0d_high0", p), h0, per[p].h0);
      check_output($sformatf("period%0d_high1", p), h1, per[p].h1);
      check_output($sformatf("period%0d_underflow", p), uf, per[p].uf);
    end

    bus.req = 1'b1;
    bus.din = 8'h21;
    apply_stimulus();
    bus.req = 1'b0;
    apply_stimulus();
    bus.req = 1'b1;
    bus.din = 8'h43;
    apply_stimulus();
    check_output("pre_reset_ack", 32'(bus.ack), 1);
    check_output("pre_reset_count", 32'(fifo_count), 2);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_reset_ack", 32'(bus.ack), 0);
    check_output("async_reset_pwm", 32'(pwm), 0);
    check_output("async_reset_count", 32'(fifo_count), 0);
    check_output("async_reset_empty", 32'(fifo_empty), 1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus();
    check_output("post_reset_push_ack", 32'(bus.ack), 1);
    check_output("post_reset_push_count", 32'(fifo_count), 1);

    for (int s = 0; s < 4; s++) begin
      repeat (200) begin
        en = ($urandom_range(0, 9) != 0);
        if (!bus.req && !bus.ack) begin
          if ($urandom_range(0, 99) < push_pct[s]) begin
            bus.req = 1'b1;
            bus.din = {pick_duty(), pick_duty()};
          end
        end else if (bus.req && bus.ack) begin
          if ($urandom_range(0, 1) == 1) bus.req = 1'b0;
        end
        apply_stimulus();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
